// File: rtl/ccff_bitstream_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
//   Shared constants for the configuration-chain bitstream loader:
//   FSM state encodings and a helper for the number of words in one load.
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of words needed to cover chain_len bits: ceil(chain_len / word_w).
   function automatic int unsigned word_count(input int unsigned chain_len,
                                              input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader_if
//   Valid/ready word channel feeding the bitstream loader.
//   cfg_valid/cfg_data : producer -> loader
//   cfg_ready          : loader -> producer
//   master = producer side, slave = loader side.
// ---------------------------------------------------------------------------
interface ccff_bitstream_loader_if #(
   parameter int unsigned WORD_W = 8
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [WORD_W-1:0] cfg_data;

   modport master (output cfg_valid, output cfg_data, input  cfg_ready);
   modport slave  (input  cfg_valid, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
//   Two-stage word pipe (holding register + shift register) producing an
//   MSB-first bit stream.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous clear of both stages (new load)
//   push       : accept push_data this cycle (caller guarantees !hold_full)
//   pop        : consume the current bit this cycle (only while bit_valid)
//   hold_full  : holding register occupied
//   bit_valid  : a bit is available in the shift register
//   head       : current bit while popping, otherwise the last bit popped
// ---------------------------------------------------------------------------
module ccff_word_serializer #(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic              hold_full,
   output logic              bit_valid,
   output logic              head
);

   localparam int unsigned CW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] hold_q, hold_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic              hold_full_q, hold_full_d;
   logic [CW-1:0]     left_q, left_d;
   logic              last_q, last_d;
   logic              refill;

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sh_d        = sh_q;
      left_d      = left_q;
      last_d      = last_q;
      // Shift stage frees up this cycle: refill it without a bubble.
      refill      = (left_q == '0) || ((left_q == CW'(1)) && pop);

      if (pop) begin
         sh_d   = {sh_q[WORD_W-2:0], 1'b0};
         left_d = left_q - CW'(1);
         last_d = sh_q[WORD_W-1];
      end

      if (refill && hold_full_q) begin
         sh_d        = hold_q;
         left_d      = CW'(WORD_W);
         hold_full_d = 1'b0;
      end else if (refill && push) begin
         // Empty pipe: the incoming word bypasses the holding register.
         sh_d   = push_data;
         left_d = CW'(WORD_W);
      end

      if (push && !(refill && !hold_full_q)) begin
         hold_d      = push_data;
         hold_full_d = 1'b1;
      end

      // Surplus bits from the previous load are dropped; head keeps its value.
      if (flush) begin
         hold_d      = '0;
         hold_full_d = 1'b0;
         sh_d        = '0;
         left_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         sh_q        <= '0;
         left_q      <= '0;
         last_q      <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sh_q        <= sh_d;
         left_q      <= left_d;
         last_q      <= last_d;
      end
   end

   assign hold_full = hold_full_q;
   assign bit_valid = (left_q != '0);
   assign head      = pop ? sh_q[WORD_W-1] : last_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//   Serialises bitstream words MSB-first onto a configuration flop chain,
//   shifting exactly CHAIN_LEN bits per load, then reports done.
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   start                : begin a load (ignored while loading)
//   cfg                  : valid/ready word channel (slave)
//   ccff_head            : serial bit to chain head
//   ccff_shift_en        : chain shifts on this prog_clk edge
//   ccff_tail            : chain far-end bit (loopback check only)
//   busy / done          : load in progress / load complete
//   loopback_err         : verify-pass mismatch, present only when
//                          CCFF_LOOPBACK_CHECK_EN is defined
// ---------------------------------------------------------------------------
module ccff_bitstream_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CHAIN_LEN = 64
) (
   input  logic                     prog_clk,
   input  logic                     prog_reset,
   input  logic                     start,
   ccff_bitstream_loader_if.slave   cfg,
   output logic                     ccff_head,
   output logic                     ccff_shift_en,
   input  logic                     ccff_tail,
   output logic                     busy,
   output logic                     done
`ifdef CCFF_LOOPBACK_CHECK_EN
   ,
   output logic                     loopback_err
`endif
);

   localparam int unsigned CNT_W   = $clog2(CHAIN_LEN + 1);
   localparam int unsigned N_WORDS = word_count(CHAIN_LEN, WORD_W);
   localparam int unsigned WCNT_W  = $clog2(N_WORDS + 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WCNT_W-1:0] words_q, words_d;
   logic              start_ok, push, hold_full, bit_valid;

   always_comb begin
      start_ok      = start && (state_q != ST_LOAD);
      ccff_shift_en = (state_q == ST_LOAD) && bit_valid;
      cfg.cfg_ready = (state_q == ST_LOAD) && !hold_full &&
                      (words_q != WCNT_W'(N_WORDS));
      push          = cfg.cfg_valid && cfg.cfg_ready;

      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      words_d   = words_q;
      if (start_ok) begin
         state_d   = ST_LOAD;
         bit_cnt_d = '0;
         words_d   = '0;
      end else if (state_q == ST_LOAD) begin
         if (push) words_d = words_q + WCNT_W'(1);
         if (ccff_shift_en) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         words_q   <= words_d;
      end
   end

   assign busy = (state_q == ST_LOAD);
   assign done = (state_q == ST_DONE);

   ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk       (prog_clk),
      .rst       (prog_reset),
      .flush     (start_ok),
      .push      (push),
      .push_data (cfg.cfg_data),
      .pop       (ccff_shift_en),
      .hold_full (hold_full),
      .bit_valid (bit_valid),
      .head      (ccff_head)
   );

`ifdef CCFF_LOOPBACK_CHECK_EN
   // Delay line mirrors the chain: its far end equals what the tail should
   // present once a full pass has been shifted in.
   logic [CHAIN_LEN-1:0] dly_q, dly_d;
   logic                 verify_q, verify_d, err_q, err_d;

   always_comb begin
      dly_d    = dly_q;
      verify_d = verify_q;
      err_d    = err_q;
      if (ccff_shift_en) dly_d = CHAIN_LEN'({dly_q, ccff_head});
      if (start_ok) begin
         verify_d = (state_q == ST_DONE);
         err_d    = 1'b0;
      end else if (ccff_shift_en && verify_q && (dly_q[CHAIN_LEN-1] != ccff_tail)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         dly_q    <= '0;
         verify_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         dly_q    <= dly_d;
         verify_q <= verify_d;
         err_q    <= err_d;
      end
   end

   assign loopback_err = err_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//   Randomised self-checking bench. A queue-based model holds the bits that
//   should reach the chain (first CHAIN_LEN bits of accepted words, MSB
//   first); every cycle the DUT outputs are checked against it.
//   Define CCFF_LOOPBACK_CHECK_EN to also exercise loopback_err.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

   localparam int unsigned WORD_W    = 8;
   localparam int unsigned CHAIN_LEN = 20;
   localparam int unsigned N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;

   logic prog_clk = 1'b0;
   logic prog_reset, start, ccff_head, ccff_shift_en, ccff_tail, busy, done;

   ccff_bitstream_loader_if #(.WORD_W(WORD_W)) cfg ();

`ifdef CCFF_LOOPBACK_CHECK_EN
   logic                 loopback_err;
   logic [CHAIN_LEN-1:0] chain_q = '0;
   logic                 corrupt = 1'b0;
   always @(posedge prog_clk) if (ccff_shift_en) chain_q <= {chain_q[CHAIN_LEN-2:0], ccff_head};
   assign ccff_tail = chain_q[CHAIN_LEN-1] ^ corrupt;
`else
   assign ccff_tail = 1'b0;
`endif

   ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk      (prog_clk),
      .prog_reset    (prog_reset),
      .start         (start),
      .cfg           (cfg),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done)
`ifdef CCFF_LOOPBACK_CHECK_EN
      ,
      .loopback_err  (loopback_err)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int                phase;       // 0 idle, 1 loading, 2 done
   bit                exp_q[$];    // bits still owed to the chain
   bit                run_bits[$];
   bit                prev_bits[$];
   logic [WORD_W-1:0] word_src[$], run_words[$], last_words[$];
   logic [WORD_W-1:0] cur_word;
   bit                have_word, last_bit, verify, err_exp;
   int                pulses, dut_pulses, pushed, words_sent, corrupt_idx;

   task automatic clear_run();
      exp_q.delete(); run_bits.delete(); run_words.delete();
      pulses = 0; dut_pulses = 0; pushed = 0; words_sent = 0;
   endtask

   // One cycle: check outputs at the negedge, then drive the next inputs.
   task automatic step(input bit want_valid, input bit do_start, input bit do_reset);
      int ph_now;
      bit b;
      @(negedge prog_clk);
      ph_now = phase;
      check("shift_en", ccff_shift_en, (phase == 1) && (exp_q.size() > 0));
      check("busy", busy, phase == 1);
      check("done", done, phase == 2);
      if (phase != 1 || words_sent == N_WORDS) check("ready_low", cfg.cfg_ready, 1'b0);
`ifdef CCFF_LOOPBACK_CHECK_EN
      check("loopback_err", loopback_err, err_exp);
      corrupt = 1'b0;
`endif
      if (ccff_shift_en) dut_pulses++;
      if (ccff_shift_en && exp_q.size() > 0) begin
         b = exp_q.pop_front();
         check("head", ccff_head, b);
`ifdef CCFF_LOOPBACK_CHECK_EN
         if (verify) begin
            corrupt = (pulses == corrupt_idx);
            if ((prev_bits[pulses] ^ corrupt) != b) err_exp = 1'b1;
         end
`endif
         last_bit = b;
         run_bits.push_back(b);
         pulses++;
         if (pulses == CHAIN_LEN) phase = 2;
      end else begin
         check("head_hold", ccff_head, last_bit);
      end

      prog_reset = do_reset;
      start      = do_start && !do_reset;
      if (do_reset) begin
         phase = 0; last_bit = 0; have_word = 0; verify = 0; err_exp = 0;
         clear_run();
      end else if (do_start && ph_now != 1) begin
         verify = (ph_now == 2);
         if (verify) prev_bits = run_bits;
         err_exp     = 0;
         corrupt_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, CHAIN_LEN - 1)) : -1;
         phase = 1;
         clear_run();
      end

      if (want_valid && !have_word && !do_reset) begin
         cur_word  = (word_src.size() > 0) ? word_src.pop_front() : WORD_W'($urandom);
         have_word = 1;
      end
      cfg.cfg_valid = have_word;
      cfg.cfg_data  = cur_word;
      if (have_word && cfg.cfg_ready && !do_reset) begin
         for (int i = WORD_W - 1; i >= 0; i--)
            if (pushed < CHAIN_LEN) begin exp_q.push_back(cur_word[i]); pushed++; end
         run_words.push_back(cur_word);
         words_sent++;
         have_word = 0;
      end
   endtask

   task automatic run_load(input int unsigned maxgap, input bit reset_run, input bit stray);
      int  cyc, idle_left, ws;
      bit  did_reset, wv, ds, dr;
      cyc = 0; idle_left = 0; did_reset = 0;
      step(1'b0, 1'b1, 1'b0);
      while (phase != 2 && cyc < 400) begin
         wv = (phase == 1) && (words_sent < N_WORDS) && (idle_left == 0);
         if (idle_left > 0) idle_left--;
         ds = (phase == 0) || (stray && phase == 1 && $urandom_range(0, 7) == 0);
         dr = reset_run && !did_reset && phase == 1 && pulses == 5;
         if (dr) did_reset = 1;
         ws = words_sent;
         step(wv, ds, dr);
         if (words_sent != ws) idle_left = $urandom_range(0, maxgap);
         cyc++;
      end
      if (phase != 2) check("run_timeout", done, 1'b1);
      check("pulse_count", dut_pulses, CHAIN_LEN);
      last_words = run_words;
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [CHAIN_LEN-1:0] v;
      prog_reset = 1; start = 0; cfg.cfg_valid = 0; cfg.cfg_data = '0;
      phase = 0; have_word = 0; last_bit = 0; verify = 0; err_exp = 0; corrupt_idx = -1;
      clear_run();

      repeat (3) @(negedge prog_clk);
      check("rst_shift_en", ccff_shift_en, 1'b0);
      check("rst_head", ccff_head, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ready", cfg.cfg_ready, 1'b0);

      // Valid without start: nothing may be accepted.
      repeat (4) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Nominal back-to-back stream with known words.
      word_src.delete();
      word_src.push_back(8'hA5); word_src.push_back(8'h3C); word_src.push_back(8'hF0);
      run_load(0, 1'b0, 1'b0);
      v = '0;
      foreach (run_bits[i]) v = {v[CHAIN_LEN-2:0], run_bits[i]};
      check("nominal_bits", v, 20'hA53CF);

      // Randomised loads: gaps, stray starts, mid-load resets, repeated passes.
      for (int r = 0; r < 40; r++) begin
         word_src.delete();
         if ($urandom_range(0, 1) == 1) word_src = last_words;
         run_load($urandom_range(0, 4), $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
Upstream feeder for the configuration-chain flops of the I/O and logic tiles. Accepts parallel bitstream words over a valid/ready handshake and serialises them MSB-first onto ccff_head, one bit per prog_clk. It drives a shift-enable used to gate the chain clock, counts exactly CHAIN_LEN bits, then reports done. The head of the tile chain connects to ccff_head; the far-end ccff_tail returns to this block.

Parameters:
WORD_W, 8, width of one bitstream word (≥2)
CHAIN_LEN, 64, total configuration bits in the attached chain (≥1)
CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived; do not override)

Ports:
prog_clk  input  1  configuration clock; only clock
prog_reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load when idle or done
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader can accept a word this cycle
cfg_data  input  WORD_W  bitstream word, MSB shifted first
ccff_head  output  1  serial bit to the chain head
ccff_shift_en  output  1  chain shifts ccff_head on this prog_clk edge
ccff_tail  input  1  chain far-end output (used only by the optional feature)
busy  output  1  load in progress
done  output  1  CHAIN_LEN bits shifted; held until next start or reset

Behaviour:
- Reset: the reset is synchronous and active-high, sampled on prog_clk. State IDLE; cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, all counters and buffers cleared. Reset mid-load aborts immediately with no further shift_en.
- FSM IDLE -> (start) LOAD -> (bit_cnt==CHAIN_LEN) DONE -> (start) LOAD. A start pulse while in LOAD is ignored.
- Two word stages: a holding register (hold_full) and a shift register (sh_bits_left).
- cfg_ready=1 in LOAD when hold_full=0 and words_accepted < ceil(CHAIN_LEN/WORD_W). It is 0 in IDLE and DONE. A word is accepted on cfg_valid&&cfg_ready.
- If the shift register is empty or on its last bit, the holding word moves into it in the same cycle. Back-to-back words therefore stream with no bubble.
- Word accepted at edge t with the pipe empty: its MSB appears on ccff_head with ccff_shift_en=1 during cycle t+1.
- Each cycle with shift_en=1 increments bit_cnt. shift_en=0 whenever no bit is available (starvation). ccff_head holds its last value while stalled.
- If CHAIN_LEN is not a multiple of WORD_W, the surplus LSBs of the final word are discarded and never shifted.
- When bit_cnt reaches CHAIN_LEN: shift_en drops in the following cycle, FSM enters DONE, done=1, busy=0.
- busy=1 exactly while in LOAD.
- start in DONE: clears done and the counters, then re-enters LOAD.

Optional Feature:
CCFF_LOOPBACK_CHECK_EN.
- Defined: adds output loopback_err (1 bit, reset 0). During every shift with bit_cnt ≥ CHAIN_LEN − (bits still to come) … more precisely, the block delays the ccff_head stream by CHAIN_LEN shifts (shift-register FIFO) and compares it with ccff_tail on each shift_en cycle.
- After load, an extra verify pass is requested by start while in DONE with cfg stream repeated. Any mismatch in that pass sets loopback_err (sticky until start or reset).
- Not defined: the port is absent, ccff_tail is unused, and no delay storage is built.

Decomposition:
- Package ccff_loader_pkg: FSM state enum (ST_IDLE, ST_LOAD, ST_DONE), and helper constant function for word count ceil(CHAIN_LEN/WORD_W).
- One sub-module is natural: ccff_word_serializer (holding register + shift register + MSB-first output, valid/ready in, bit/valid out). The top holds the FSM, the bit counter and the optional check.

Test Plan:
- Reset then idle: hold prog_reset 3 cycles, release -> all outputs 0; cfg_valid=1 with no start -> cfg_ready stays 0.
- Nominal stream: WORD_W=8, CHAIN_LEN=16, start, words 0xA5 and 0x3C presented continuously -> ccff_head=1010010100111100 over 16 consecutive shift_en cycles; done=1 on the next cycle after the last bit; cfg_ready=0 after 2 words.
- Non-multiple length: CHAIN_LEN=12, words 0xFF and 0x0F -> exactly 12 shift_en pulses, bits 11111111 0000; the low 4 bits of the second word are never shifted.
- Starvation: insert 3 idle cycles between words -> shift_en=0 for those cycles, bit_cnt unchanged, ccff_head stable, total pulses still CHAIN_LEN.
- Mid-load reset: assert prog_reset after 5 bits -> next cycle shift_en=0, busy=0, done=0; a new start reloads from bit 0.
- Restart from DONE (plus, with CCFF_LOOPBACK_CHECK_EN, a chain model of CHAIN_LEN flops): start again -> done clears and a full reload occurs; corrupting one tail bit in the verify pass -> loopback_err=1 and stays set.
